// File: rtl/scene_loader_if.sv
// rtl/scene_loader_if.sv - byte-in / record-out handshake bundle for scene_loader
// master: the loader itself; slave: host byte source plus scene buffer side.
interface scene_loader_if #(
  parameter int DATA_WIDTH = 96
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [7:0]            in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/scene_loader.sv
// rtl/scene_loader.sv - assembles host command bytes into model-instance records
// Optional idle-byte timeout in PAYLOAD: define SCENE_LOADER_TIMEOUT_EN.
module scene_loader #(
  parameter int DATA_WIDTH     = 96,
  parameter int MAX_INSTANCES  = 50,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  scene_loader_if.master                       bus,
  output logic                                 scene_done_o,
  output logic [$clog2(MAX_INSTANCES+1)-1:0]   instance_count_o,
  output logic                                 error_o
);

  localparam int NBYTES = (DATA_WIDTH + 7) / 8;
  localparam int CW     = $clog2(MAX_INSTANCES + 1);
  localparam int BW     = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_INSTANCES);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, EMIT} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [BW-1:0]         byte_cnt_q;
  logic [CW-1:0]         count_q;
  logic                  last_flag_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic                  out_last_q;
  logic                  scene_done_q;
  logic                  error_q;
  logic                  in_fire;
  logic                  out_fire;

`ifdef SCENE_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q;
`endif

  assign in_fire  = bus.in_valid && in_ready_q;
  assign out_fire = out_valid_q && bus.out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      byte_cnt_q   <= '0;
      count_q      <= '0;
      last_flag_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      scene_done_q <= 1'b0;
      error_q      <= 1'b0;
`ifdef SCENE_LOADER_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      scene_done_q <= 1'b0;
      error_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_fire) begin
            case (bus.in_data)
              8'h00: ;
              8'h01, 8'h02: begin
                // ADD_LAST is never refused so a full scene can still be closed
                if (bus.in_data[1] || count_q < MAX_CNT) begin
                  last_flag_q <= bus.in_data[1];
                  byte_cnt_q  <= '0;
                  state_q     <= PAYLOAD;
`ifdef SCENE_LOADER_TIMEOUT_EN
                  tmo_q       <= '0;
`endif
                end else begin
                  error_q <= 1'b1;
                end
              end
              default: error_q <= 1'b1;
            endcase
          end
        end
        PAYLOAD: begin
          if (in_fire) begin
            shift_q    <= (shift_q << 8) | DATA_WIDTH'(bus.in_data);
            byte_cnt_q <= byte_cnt_q + BW'(1);
`ifdef SCENE_LOADER_TIMEOUT_EN
            tmo_q      <= '0;
`endif
            if (byte_cnt_q == LAST_BYTE) begin
              out_valid_q <= 1'b1;
              out_last_q  <= last_flag_q;
              in_ready_q  <= 1'b0;
              state_q     <= EMIT;
            end
          end
`ifdef SCENE_LOADER_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            error_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
`endif
        end
        EMIT: begin
          if (out_fire) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
            if (out_last_q) begin
              count_q      <= '0;
              scene_done_q <= 1'b1;
            end else if (count_q != MAX_CNT) begin
              count_q <= count_q + CW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = shift_q;
  assign bus.out_last     = out_last_q;
  assign scene_done_o     = scene_done_q;
  assign instance_count_o = count_q;
  assign error_o          = error_q;

endmodule
